// File: rtl/l1_tag_mesi_ctrl_pkg.sv
// Shared types and default geometry for the L1 tag/MESI controller.
package mypkg;
    localparam int DEF_ADDR_BITS   = 32;
    localparam int DEF_OFFSET_BITS = 6;
    localparam int DEF_INDEX_BITS  = 4;
    localparam int DEF_WAYS        = 4;
    localparam int DEF_CNT_W       = 32;

    typedef enum logic [3:0] {
        READ       = 4'd0,
        WRITE      = 4'd1,
        I_FETCH    = 4'd2,
        L2_INVAL   = 4'd3,
        L2_DATA_RQ = 4'd4,
        CLR        = 4'd8
    } cmd_e;

    typedef enum logic [1:0] {MESI_I, MESI_S, MESI_E, MESI_M} mesi_e;

    typedef enum logic [1:0] {MSG_READ, MSG_RFO, MSG_WRITEBACK, MSG_INVALIDATE} l2_msg_e;

    typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_VICTIM_WB, ST_RESP, ST_CLEAR} fsm_e;
endpackage

// File: rtl/l1_tag_mesi_ctrl_lru_age_update.sv
// Age-based LRU update: the touched way becomes youngest, younger ways age by one.
module lru_age_update #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-1:0][$clog2(WAYS)-1:0] ages_in,
    input  logic [$clog2(WAYS)-1:0]           way,
    output logic [WAYS-1:0][$clog2(WAYS)-1:0] ages_out
);
    localparam int AW = $clog2(WAYS);

    always_comb begin
        // NOTE: default every always_comb output first so no path can infer a latch.
        ages_out = ages_in;
        for (int w = 0; w < WAYS; w++) begin
            if (AW'(w) == way)
                ages_out[w] = '0;
            else if (ages_in[w] < ages_in[way])
                ages_out[w] = ages_in[w] + AW'(1);
        end
    end
endmodule

// File: rtl/l1_tag_mesi_ctrl.sv
// L1 tag array with MESI coherence state, age-based LRU, L2 messaging and statistics.
module l1_tag_mesi_ctrl
    import mypkg::*;
#(
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int OFFSET_BITS = DEF_OFFSET_BITS,
    parameter int INDEX_BITS  = DEF_INDEX_BITS,
    parameter int WAYS        = DEF_WAYS,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3:0]              req_cmd,
    input  logic [ADDR_BITS-1:0]    req_addr,
    output logic                    rsp_valid,
    output logic                    rsp_hit,
    output logic [$clog2(WAYS)-1:0] rsp_way,
    output logic                    rsp_err,
    output logic                    l2_msg_valid,
    output l2_msg_e                 l2_msg_type,
    output logic [ADDR_BITS-1:0]    l2_msg_addr,
    output logic [CNT_W-1:0]        read_cnt,
    output logic [CNT_W-1:0]        write_cnt,
    output logic [CNT_W-1:0]        hit_cnt,
    output logic [CNT_W-1:0]        miss_cnt
);
    localparam int SETS      = 1 << INDEX_BITS;
    localparam int AW        = $clog2(WAYS);
    localparam int LINE_BITS = ADDR_BITS - OFFSET_BITS;
    localparam int TAG_BITS  = LINE_BITS - INDEX_BITS;

    fsm_e                  fsm;
    logic [3:0]            cmd_q;
    logic [LINE_BITS-1:0]  line_q;
    logic [INDEX_BITS-1:0] set_q, clr_set;
    logic [TAG_BITS-1:0]   tag_q;

    logic [TAG_BITS-1:0]       tag_mem  [SETS][WAYS];
    mesi_e                     mesi_mem [SETS][WAYS];
    logic [WAYS-1:0][AW-1:0]   age_mem  [SETS];

    logic                    hit, inv_found, fill, do_wb, err, st_we, age_we, msg_v;
    logic [AW-1:0]           hit_way, inv_way, lru_way, victim_way, acc_way;
    mesi_e                   hit_st, vic_st, st_new;
    l2_msg_e                 msg_t;
    logic [ADDR_BITS-1:0]    line_addr, wb_addr;
    logic [WAYS-1:0][AW-1:0] ages_next;

    logic                    pend_hit;
    logic [AW-1:0]           pend_way;
    l2_msg_e                 pend_msg_t;
    logic [ADDR_BITS-1:0]    pend_msg_addr;

    assign req_ready = (fsm == ST_IDLE);
    assign set_q     = line_q[INDEX_BITS-1:0];
    assign tag_q     = line_q[LINE_BITS-1:INDEX_BITS];
    assign line_addr = {line_q, OFFSET_BITS'(0)};

    always_comb begin
        hit = 1'b0; hit_way = '0; inv_found = 1'b0; inv_way = '0; lru_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && mesi_mem[set_q][w] != MESI_I && tag_mem[set_q][w] == tag_q) begin
                hit = 1'b1; hit_way = AW'(w);
            end
            if (!inv_found && mesi_mem[set_q][w] == MESI_I) begin
                inv_found = 1'b1; inv_way = AW'(w);
            end
            if (age_mem[set_q][w] == AW'(WAYS - 1))
                lru_way = AW'(w);
        end
    end

    assign victim_way = inv_found ? inv_way : lru_way;
    assign acc_way    = hit ? hit_way : victim_way;
    assign hit_st     = mesi_mem[set_q][hit_way];
    assign vic_st     = mesi_mem[set_q][victim_way];
    assign wb_addr    = {tag_mem[set_q][victim_way], set_q, OFFSET_BITS'(0)};
    assign do_wb      = fill && (vic_st == MESI_M);

    lru_age_update #(.WAYS(WAYS)) u_lru (
        .ages_in (age_mem[set_q]),
        .way     (acc_way),
        .ages_out(ages_next)
    );

    always_comb begin
        st_new = hit_st; st_we = 1'b0; age_we = 1'b0; fill = 1'b0;
        msg_v = 1'b0; msg_t = MSG_READ; err = 1'b0;
        case (cmd_q)
            READ, I_FETCH: begin
                age_we = 1'b1;
                if (!hit) begin
                    fill = 1'b1; st_we = 1'b1; st_new = MESI_E; msg_v = 1'b1; msg_t = MSG_READ;
                end
            end
            WRITE: begin
                age_we = 1'b1; st_we = 1'b1; st_new = MESI_M;
                if (!hit) begin
                    fill = 1'b1; msg_v = 1'b1; msg_t = MSG_RFO;
                end else if (hit_st == MESI_S) begin
                    msg_v = 1'b1; msg_t = MSG_INVALIDATE;
                end
            end
            L2_INVAL: if (hit) begin
                st_we = 1'b1; st_new = MESI_I;
                msg_v = (hit_st == MESI_M); msg_t = MSG_WRITEBACK;
            end
            L2_DATA_RQ: if (hit && (hit_st == MESI_M || hit_st == MESI_E)) begin
                st_we = 1'b1; st_new = MESI_S;
                msg_v = (hit_st == MESI_M); msg_t = MSG_WRITEBACK;
            end
            default: err = 1'b1;
        endcase
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // NOTE: tags need no reset; a line is only trusted when its reset-cleared MESI state is not I.
    always_ff @(posedge clk) begin
        if (fsm == ST_LOOKUP && fill)
            tag_mem[set_q][victim_way] <= tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= ST_IDLE;
            cmd_q <= '0; line_q <= '0; clr_set <= '0;
            rsp_valid <= 1'b0; rsp_hit <= 1'b0; rsp_way <= '0; rsp_err <= 1'b0;
            l2_msg_valid <= 1'b0; l2_msg_type <= MSG_READ; l2_msg_addr <= '0;
            pend_hit <= 1'b0; pend_way <= '0; pend_msg_t <= MSG_READ; pend_msg_addr <= '0;
            read_cnt <= '0; write_cnt <= '0; hit_cnt <= '0; miss_cnt <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    mesi_mem[s][w] <= MESI_I;
                    age_mem[s][w]  <= AW'(w);
                end
        end else begin
            rsp_valid    <= 1'b0;
            l2_msg_valid <= 1'b0;
            case (fsm)
                ST_IDLE: if (req_valid) begin
                    cmd_q   <= req_cmd;
                    line_q  <= req_addr[ADDR_BITS-1:OFFSET_BITS];
                    clr_set <= '0;
                    fsm     <= (req_cmd == CLR) ? ST_CLEAR : ST_LOOKUP;
                end
                ST_CLEAR: begin
                    for (int w = 0; w < WAYS; w++) begin
                        mesi_mem[clr_set][w] <= MESI_I;
                        age_mem[clr_set][w]  <= AW'(w);
                    end
                    read_cnt <= '0; write_cnt <= '0; hit_cnt <= '0; miss_cnt <= '0;
                    clr_set <= clr_set + INDEX_BITS'(1);
                    if (clr_set == INDEX_BITS'(SETS - 1)) begin
                        rsp_valid <= 1'b1; rsp_hit <= 1'b0; rsp_way <= '0; rsp_err <= 1'b0;
                        fsm <= ST_RESP;
                    end
                end
                ST_LOOKUP: begin
                    if (st_we)  mesi_mem[set_q][acc_way] <= st_new;
                    if (age_we) age_mem[set_q] <= ages_next;
                    if (cmd_q == READ || cmd_q == I_FETCH) read_cnt <= sat_inc(read_cnt);
                    if (cmd_q == WRITE) write_cnt <= sat_inc(write_cnt);
                    if (age_we) begin
                        if (hit) hit_cnt  <= sat_inc(hit_cnt);
                        else     miss_cnt <= sat_inc(miss_cnt);
                    end
                    if (do_wb) begin
                        // The writeback owns this cycle; the fill message waits for RESP.
                        l2_msg_valid <= 1'b1; l2_msg_type <= MSG_WRITEBACK; l2_msg_addr <= wb_addr;
                        pend_hit <= 1'b0; pend_way <= acc_way;
                        pend_msg_t <= msg_t; pend_msg_addr <= line_addr;
                        fsm <= ST_VICTIM_WB;
                    end else begin
                        rsp_valid <= 1'b1; rsp_hit <= hit && !err; rsp_way <= acc_way; rsp_err <= err;
                        l2_msg_valid <= msg_v; l2_msg_type <= msg_t; l2_msg_addr <= line_addr;
                        fsm <= ST_RESP;
                    end
                end
                ST_VICTIM_WB: begin
                    rsp_valid <= 1'b1; rsp_hit <= pend_hit; rsp_way <= pend_way; rsp_err <= 1'b0;
                    l2_msg_valid <= 1'b1; l2_msg_type <= pend_msg_t; l2_msg_addr <= pend_msg_addr;
                    fsm <= ST_RESP;
                end
                ST_RESP: fsm <= ST_IDLE;
                default: fsm <= ST_IDLE;
            endcase
        end
    end
endmodule
